// File: rtl/fu_complete_arb.sv
// Completion arbiter: per-FU result FIFOs feeding NUM_CDB broadcast ports.
// Grants use fixed priority (highest index first) or round-robin from rr_q.
module fu_complete_arb #(
  parameter int NUM_FU  = 6,
  parameter int DEPTH   = 2,
  parameter int NUM_CDB = 1,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int RR_MODE = 0,
  parameter int SRC_W   = $clog2(NUM_FU)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        cdb_stall,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic [NUM_CDB*SRC_W-1:0]    cdb_src,
  output logic [NUM_FU-1:0]           fu_free
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0] mem_q   [NUM_FU][DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_FU];
  logic [PTR_W-1:0] head_d  [NUM_FU];
  logic [PTR_W-1:0] tail_q  [NUM_FU];
  logic [PTR_W-1:0] tail_d  [NUM_FU];
  logic [CNT_W-1:0] count_q [NUM_FU];
  logic [CNT_W-1:0] count_d [NUM_FU];
  logic [SRC_W-1:0] rr_q;
  logic [SRC_W-1:0] rr_d;

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;
  logic              found;
  int                rank_idx;
  logic [SRC_W-1:0]  sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered count, so a full FIFO refuses a push even while popping.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_ch
    assign fu_ready[gi] = (count_q[gi] != CNT_W'(DEPTH));
    assign push[gi]     = fu_valid[gi] & fu_ready[gi];
  end

  assign fu_free = grant;

  always_comb begin
    grant     = '0;
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
    cdb_src   = '0;
    rr_d      = rr_q;
    found     = 1'b0;
    rank_idx  = 0;
    sel       = '0;
    if (!cdb_stall && !flush) begin
      for (int p = 0; p < NUM_CDB; p++) begin
        found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
          if (RR_MODE != 0) begin
            rank_idx = int'(rr_q) + k;
            if (rank_idx >= NUM_FU) rank_idx = rank_idx - NUM_FU;
          end else begin
            rank_idx = NUM_FU - 1 - k;
          end
          sel = SRC_W'(rank_idx);
          if (!found && (count_q[sel] != '0) && !grant[sel]) begin
            found                        = 1'b1;
            grant[sel]                   = 1'b1;
            cdb_valid[p]                 = 1'b1;
            cdb_tag[p*TAG_W +: TAG_W]    = mem_q[sel][head_q[sel]][DATA_W +: TAG_W];
            cdb_data[p*DATA_W +: DATA_W] = mem_q[sel][head_q[sel]][0 +: DATA_W];
            cdb_src[p*SRC_W +: SRC_W]    = sel;
            // Later ports overwrite, leaving the highest-numbered valid port's channel.
            rr_d = (rank_idx == NUM_FU - 1) ? '0 : SRC_W'(rank_idx + 1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (push[i])  tail_d[i] = ptr_inc(tail_q[i]);
        if (grant[i]) head_d[i] = ptr_inc(head_q[i]);
        if (push[i] && !grant[i])      count_d[i] = count_q[i] + 1'b1;
        else if (!push[i] && grant[i]) count_d[i] = count_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      rr_q <= flush ? '0 : rr_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i] && !flush) begin
        mem_q[i][tail_q[i]] <= {fu_tag[i*TAG_W +: TAG_W], fu_data[i*DATA_W +: DATA_W]};
      end
    end
  end

endmodule
